// File: rtl/tape_pkg.sv
// rtl/tape_pkg.sv - shared types and default constants for the tape transport
//
// Purpose: FSM state encoding, direction constants and the default speed and
// geometry constants shared between the deck model and the mode FSM bench.
// Ports: none (package).
package tape_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    RUN,
    BRAKE
  } tape_state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  localparam int DEF_POS_W    = 16;
  localparam int DEF_TAPE_LEN = 1000;
  localparam int DEF_PRESCALE = 4;
  localparam int DEF_PLAY_SPD = 1;
  localparam int DEF_FAST_SPD = 4;
  localparam int DEF_SPD_W    = 4;

  // True when two or more of the three motor commands are high.
  function automatic logic multi_hot3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tape_transport_if.sv
// rtl/tape_transport_if.sv - P/R/F command and deck status interface
//
// Purpose: bundles the motor commands from the control side with the deck
// status returned by the transport.
// Signals: P, R, F (commands, master -> slave); pos, speed, dir, moving, bot,
// eot, end_pulse (status, slave -> master); cmd_err when TAPE_CMD_CHECK_EN.
// Configuration: TAPE_CMD_CHECK_EN adds cmd_err.
interface tape_transport_if #(
  parameter int POS_W = 16,
  parameter int SPD_W = 4
);
  logic             P;
  logic             R;
  logic             F;
  logic [POS_W-1:0] pos;
  logic [SPD_W-1:0] speed;
  logic             dir;
  logic             moving;
  logic             bot;
  logic             eot;
  logic             end_pulse;
`ifdef TAPE_CMD_CHECK_EN
  logic             cmd_err;

  modport master (
    output P, R, F,
    input  pos, speed, dir, moving, bot, eot, end_pulse, cmd_err
  );
  modport slave (
    input  P, R, F,
    output pos, speed, dir, moving, bot, eot, end_pulse, cmd_err
  );
`else
  modport master (
    output P, R, F,
    input  pos, speed, dir, moving, bot, eot, end_pulse
  );
  modport slave (
    input  P, R, F,
    output pos, speed, dir, moving, bot, eot, end_pulse
  );
`endif
endinterface

// File: rtl/tape_prescaler.sv
// rtl/tape_prescaler.sv - motion tick generator
//
// Purpose: free-running counter 0..PRESCALE-1; tick is high for the cycle in
// which the count sits at PRESCALE-1, so the first tick edge is the
// PRESCALE-th rising edge after reset releases.
// Ports: Clk (clock), Rst (async active-high reset), tick (one cycle per period).
module tape_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic Clk,
  input  logic Rst,
  output logic tick
);
  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(PRESCALE - 1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/tape_transport.sv
// rtl/tape_transport.sv - tape deck transport: speed ramping, direction, position
//
// Purpose: turns P/R/F motor commands into a ramped speed, a direction and an
// absolute tape position, stopping hard at either end of the tape.
// Ports: Clk, Rst (async active-high); bus (tape_transport_if.slave):
//   P/R/F in; pos, speed, dir, moving, bot, eot, end_pulse out.
// Configuration: TAPE_CMD_CHECK_EN adds cmd_err and makes multi-hot commands
//   a stop request; otherwise they decode with priority P > F > R.
module tape_transport
  import tape_pkg::*;
#(
  parameter int POS_W    = DEF_POS_W,
  parameter int TAPE_LEN = DEF_TAPE_LEN,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int PLAY_SPD = DEF_PLAY_SPD,
  parameter int FAST_SPD = DEF_FAST_SPD,
  parameter int SPD_W    = DEF_SPD_W
) (
  input logic            Clk,
  input logic            Rst,
  tape_transport_if.slave bus
);
  localparam logic [SPD_W-1:0] PLAY = SPD_W'(PLAY_SPD);
  localparam logic [SPD_W-1:0] FAST = SPD_W'(FAST_SPD);
  localparam logic [POS_W-1:0] LAST = POS_W'(TAPE_LEN);
  localparam logic [POS_W:0]   LAST_EXT = (POS_W + 1)'(TAPE_LEN);

  logic             tick;
  tape_state_t      state_q, state_d;
  logic [SPD_W-1:0] spd_q, spd_d, raw_spd, tgt_spd;
  logic             dir_q, dir_d, raw_dir, tgt_dir;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             end_q, end_d;
  logic             bot_w, eot_w, cmd_ok, same_dir, braking, hit;
  logic [POS_W:0]   pos_ext, spd_ext, fwd_sum;

  tape_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .Clk  (Clk),
    .Rst  (Rst),
    .tick (tick)
  );

  assign bot_w   = (pos_q == '0);
  assign eot_w   = (pos_q == LAST);
  assign pos_ext = {1'b0, pos_q};

  // Command decode, then block any target that points into a tape limit.
  always_comb begin
    raw_spd = '0;
    raw_dir = dir_q;
    cmd_ok  = 1'b1;
`ifdef TAPE_CMD_CHECK_EN
    cmd_ok  = !multi_hot3(bus.P, bus.R, bus.F);
`endif
    if (cmd_ok) begin
      if (bus.P) begin
        raw_spd = PLAY;
        raw_dir = DIR_FWD;
      end else if (bus.F) begin
        raw_spd = FAST;
        raw_dir = DIR_FWD;
      end else if (bus.R) begin
        raw_spd = FAST;
        raw_dir = DIR_REV;
      end
    end
    tgt_dir = raw_dir;
    tgt_spd = raw_spd;
    if ((raw_dir == DIR_FWD && eot_w) || (raw_dir == DIR_REV && bot_w)) begin
      tgt_spd = '0;
    end
  end

  assign same_dir = (tgt_dir == dir_q);

  always_comb begin
    state_d = state_q;
    spd_d   = spd_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    end_d   = 1'b0;
    braking = 1'b0;
    hit     = 1'b0;
    spd_ext = '0;
    fwd_sum = '0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          // Direction is only ever loaded here, with speed at zero.
          if (tgt_spd != '0) begin
            dir_d   = tgt_dir;
            spd_d   = {{(SPD_W-1){1'b0}}, 1'b1};
            state_d = RAMP;
          end
        end
        RAMP: begin
          if (tgt_spd == '0 || !same_dir) begin
            braking = 1'b1;
          end else begin
            if (spd_q < tgt_spd) begin
              spd_d = spd_q + 1'b1;
            end else if (spd_q > tgt_spd) begin
              spd_d = spd_q - 1'b1;
            end
            state_d = (spd_d == tgt_spd) ? RUN : RAMP;
          end
        end
        RUN: begin
          if (tgt_spd == '0 || !same_dir || tgt_spd < spd_q) begin
            braking = 1'b1;
          end else if (tgt_spd > spd_q) begin
            spd_d   = spd_q + 1'b1;
            state_d = (spd_d == tgt_spd) ? RUN : RAMP;
          end
        end
        BRAKE: begin
          braking = 1'b1;
        end
        default: ;
      endcase

      // The braking step is taken on the same tick the decision is made.
      if (braking) begin
        spd_d = spd_q - 1'b1;
        if (spd_d == '0) begin
          state_d = IDLE;
        end else if (same_dir && tgt_spd != '0 && spd_d == tgt_spd) begin
          state_d = RUN;
        end else begin
          state_d = BRAKE;
        end
      end

      // Position moves by the speed just computed for this tick.
      spd_ext = (POS_W + 1)'(spd_d);
      fwd_sum = pos_ext + spd_ext;
      if (spd_d != '0) begin
        if (dir_d == DIR_FWD) begin
          if (fwd_sum >= LAST_EXT) begin
            pos_d = LAST;
            hit   = 1'b1;
          end else begin
            pos_d = fwd_sum[POS_W-1:0];
          end
        end else begin
          if (pos_ext <= spd_ext) begin
            pos_d = '0;
            hit   = 1'b1;
          end else begin
            pos_d = pos_q - spd_ext[POS_W-1:0];
          end
        end
      end

      // A tape limit stops the motor dead, without braking.
      if (hit) begin
        spd_d   = '0;
        state_d = IDLE;
        end_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      spd_q   <= '0;
      dir_q   <= DIR_FWD;
      pos_q   <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      spd_q   <= spd_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      end_q   <= end_d;
    end
  end

`ifdef TAPE_CMD_CHECK_EN
  logic cmd_err_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cmd_err_q <= 1'b0;
    end else if (tick) begin
      cmd_err_q <= multi_hot3(bus.P, bus.R, bus.F);
    end
  end

  assign bus.cmd_err = cmd_err_q;
`endif

  assign bus.pos       = pos_q;
  assign bus.speed     = spd_q;
  assign bus.dir       = dir_q;
  assign bus.moving    = (spd_q != '0);
  assign bus.bot       = bot_w;
  assign bus.eot       = eot_w;
  assign bus.end_pulse = end_q;
endmodule

// File: tb/tb_tape_transport.sv
// tb/tb_tape_transport.sv - self-checking bench for tape_transport
module tb_tape_transport;
  import tape_pkg::*;

  localparam int POS_W    = 16;
  localparam int TAPE_LEN = 100;
  localparam int PRESCALE = 4;
  localparam int PLAY_SPD = 1;
  localparam int FAST_SPD = 4;
  localparam int SPD_W    = 4;

  logic Clk = 1'b0;
  logic Rst;

  tape_transport_if #(.POS_W(POS_W), .SPD_W(SPD_W)) bus ();

  tape_transport #(
    .POS_W    (POS_W),
    .TAPE_LEN (TAPE_LEN),
    .PRESCALE (PRESCALE),
    .PLAY_SPD (PLAY_SPD),
    .FAST_SPD (FAST_SPD),
    .SPD_W    (SPD_W)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integers, advanced once per rising edge.
  int m_pos, m_spd, m_dir, m_edges;
  bit m_brk, m_cruise, m_end, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_spd = 0; m_dir = 1; m_edges = 0;
    m_brk = 0; m_cruise = 0; m_end = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int p, r, f, tgt, tdir;
    bit legal;
    m_end = 0;
    m_edges++;
    if (m_edges % PRESCALE != 0) return;
    p = int'(bus.P); r = int'(bus.R); f = int'(bus.F);
    tgt = 0; tdir = m_dir; legal = 1;
`ifdef TAPE_CMD_CHECK_EN
    m_err = (p + r + f) > 1;
    legal = !m_err;
`endif
    if (legal) begin
      if (p != 0)      begin tgt = PLAY_SPD; tdir = 1; end
      else if (f != 0) begin tgt = FAST_SPD; tdir = 1; end
      else if (r != 0) begin tgt = FAST_SPD; tdir = 0; end
    end
    if ((tdir == 1 && m_pos == TAPE_LEN) || (tdir == 0 && m_pos == 0)) tgt = 0;

    if (m_spd == 0) begin
      if (tgt > 0) begin m_dir = tdir; m_spd = 1; m_brk = 0; m_cruise = 0; end
    end else begin
      if (!m_brk && (tgt == 0 || tdir != m_dir || (m_cruise && tgt < m_spd))) m_brk = 1;
      if (m_brk) begin
        m_spd = m_spd - 1;
        if (m_spd > 0 && tgt == m_spd && tdir == m_dir) begin m_brk = 0; m_cruise = 1; end
      end else begin
        if (tgt > m_spd) m_spd = m_spd + 1;
        else if (tgt < m_spd) m_spd = m_spd - 1;
        m_cruise = (m_spd == tgt);
      end
    end
    if (m_spd == 0) begin m_brk = 0; m_cruise = 0; end

    if (m_spd > 0) begin
      if (m_dir == 1) m_pos = m_pos + m_spd;
      else            m_pos = m_pos - m_spd;
      if (m_pos >= TAPE_LEN || m_pos <= 0) begin
        m_pos = (m_pos >= TAPE_LEN) ? TAPE_LEN : 0;
        m_spd = 0; m_brk = 0; m_cruise = 0; m_end = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("pos",       32'(bus.pos),       m_pos);
    check("speed",     32'(bus.speed),     m_spd);
    check("moving",    32'(bus.moving),    32'(m_spd != 0));
    check("bot",       32'(bus.bot),       32'(m_pos == 0));
    check("eot",       32'(bus.eot),       32'(m_pos == TAPE_LEN));
    check("end_pulse", 32'(bus.end_pulse), 32'(m_end));
    if (m_spd != 0) check("dir", 32'(bus.dir), m_dir);
`ifdef TAPE_CMD_CHECK_EN
    check("cmd_err",   32'(bus.cmd_err),   32'(m_err));
`endif
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      if (Rst) model_reset();
      else     model_edge();
      #1;
      compare_all();
    end
  endtask

  task automatic set_cmd(input bit p, input bit r, input bit f);
    bus.P = p; bus.R = r; bus.F = f;
  endtask

  // Asynchronous reset asserted between edges; checked before any edge.
  task automatic do_reset();
    Rst = 1'b1;
    #1;
    model_reset();
    check("rst_pos",   32'(bus.pos),       0);
    check("rst_speed", 32'(bus.speed),     0);
    check("rst_bot",   32'(bus.bot),       1);
    check("rst_dir",   32'(bus.dir),       1);
    check("rst_mov",   32'(bus.moving),    0);
    check("rst_eot",   32'(bus.eot),       0);
    check("rst_end",   32'(bus.end_pulse), 0);
`ifdef TAPE_CMD_CHECK_EN
    check("rst_err",   32'(bus.cmd_err),   0);
`endif
    step(2);
    Rst = 1'b0;
  endtask

  initial begin
    int sel, hold;
    Rst = 1'b1;
    set_cmd(0, 0, 0);
    model_reset();
    #2;
    do_reset();

    // Play from reset: first tick on edge 4.
    set_cmd(1, 0, 0);
    step(3);
    check("t1_pre_spd", 32'(bus.speed), 0);
    step(1);
    check("t1_spd", 32'(bus.speed), 1);
    check("t1_pos", 32'(bus.pos), 1);
    step(8);
    check("t1_pos3", 32'(bus.pos), 3);

    // Fast forward from 0: speeds 1,2,3,4, positions 1,3,6,10, then +4.
    set_cmd(0, 0, 0);
    do_reset();
    set_cmd(0, 0, 1);
    step(16);
    check("t2_pos", 32'(bus.pos), 10);
    check("t2_spd", 32'(bus.speed), 4);
    step(4);
    check("t2_pos14", 32'(bus.pos), 14);

    // Reversal: brake 3,2,1,0 then one idle tick, then backward at 1.
    set_cmd(0, 1, 0);
    step(16);
    check("t3_pos", 32'(bus.pos), 20);
    check("t3_spd", 32'(bus.speed), 0);
    step(4);
    check("t3_dir", 32'(bus.dir), 0);
    check("t3_spd1", 32'(bus.speed), 1);
    check("t3_pos19", 32'(bus.pos), 19);

    // Run into the end of tape.
    set_cmd(0, 0, 1);
    for (int i = 0; i < 400 && !bus.eot; i++) step(1);
    check("t4_eot", 32'(bus.eot), 1);
    check("t4_pos", 32'(bus.pos), TAPE_LEN);
    check("t4_spd", 32'(bus.speed), 0);
    check("t4_pulse", 32'(bus.end_pulse), 1);
    step(1);
    check("t4_pulse_off", 32'(bus.end_pulse), 0);
    step(20);
    check("t4_hold_pos", 32'(bus.pos), TAPE_LEN);
    check("t4_hold_mov", 32'(bus.moving), 0);

    // Reset in mid-run, then first tick four edges after release.
    set_cmd(0, 0, 0);
    do_reset();
    set_cmd(0, 0, 1);
    step(34);
    check("t5_moving", 32'(bus.moving), 1);
    do_reset();
    step(3);
    check("t5_pre_spd", 32'(bus.speed), 0);
    step(1);
    check("t5_spd", 32'(bus.speed), 1);

    // P and F together while running fast.
    set_cmd(0, 0, 0);
    do_reset();
    set_cmd(0, 0, 1);
    step(24);
    set_cmd(1, 0, 1);
    step(40);
`ifdef TAPE_CMD_CHECK_EN
    check("t6_err", 32'(bus.cmd_err), 1);
    check("t6_spd", 32'(bus.speed), 0);
`else
    check("t6_spd", 32'(bus.speed), PLAY_SPD);
    check("t6_dir", 32'(bus.dir), 1);
`endif

    // Randomized command sequences against the model.
    set_cmd(0, 0, 0);
    do_reset();
    for (int it = 0; it < 120; it++) begin
      sel  = int'($urandom_range(0, 19));
      hold = int'($urandom_range(1, 40));
      case (sel)
        0, 1, 2:    set_cmd(0, 0, 0);
        3, 4, 5, 6: set_cmd(1, 0, 0);
        7, 8, 9, 10: set_cmd(0, 0, 1);
        11, 12, 13, 14: set_cmd(0, 1, 0);
        15: set_cmd(1, 1, 0);
        16: set_cmd(1, 0, 1);
        17: set_cmd(0, 1, 1);
        18: set_cmd(1, 1, 1);
        default: do_reset();
      endcase
      step(hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
